pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS CPU. Drives the hold/flush controls of PC, IF_ID, ID_EX and EX_M.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding
// and the hard-wired zero register number.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_BR_FLUSH = 2'd2,
      ST_MEM_WAIT = 2'd3
   } state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the 5-stage pipe (master) and the sequencer (slave).
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);

   logic [4:0]       if_id_rs_i;
   logic [4:0]       if_id_rt_i;
   logic [4:0]       id_ex_rt_i;
   logic             id_ex_memread_i;
   logic             br_taken_i;
   logic             mem_req_i;
   logic             mem_ready_i;
   logic             pc_write_o;
   logic             if_id_write_o;
   logic             if_id_flush_o;
   logic             id_ex_flush_o;
   logic             ex_m_flush_o;
   logic             freeze_o;
   logic [1:0]       state_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   logic             err_o;

   modport master (
      output if_id_rs_i, if_id_rt_i, id_ex_rt_i, id_ex_memread_i,
             br_taken_i, mem_req_i, mem_ready_i,
      input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
             ex_m_flush_o, freeze_o, state_o, stall_cnt_o, flush_cnt_o, err_o
   );

   modport slave (
      input  if_id_rs_i, if_id_rt_i, id_ex_rt_i, id_ex_memread_i,
             br_taken_i, mem_req_i, mem_ready_i,
      output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_flush_o,
             ex_m_flush_o, freeze_o, state_o, stall_cnt_o, flush_cnt_o, err_o
   );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         inc_i,
   output logic [W-1:0] value_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: drives PC/IF_ID/ID_EX/EX_M hold and flush controls for
// load-use stalls, taken-branch flushes and variable-latency memory waits.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave bus
);

   localparam int WT_W = $clog2(MEM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [WT_W-1:0]   wait_q, wait_d;
   logic              err_q, err_d;
   logic              pc_write, if_id_write, if_id_flush, id_ex_flush, ex_m_flush, freeze;
   logic              flush_inc;
   logic              load_use;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   assign load_use = bus.id_ex_memread_i && (bus.id_ex_rt_i != REG_ZERO) &&
                     ((bus.id_ex_rt_i == bus.if_id_rs_i) || (bus.id_ex_rt_i == bus.if_id_rt_i));

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      err_d       = err_q;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      ex_m_flush  = 1'b0;
      freeze      = 1'b0;
      flush_inc   = 1'b0;
      case (state_q)
         ST_MEM_WAIT: begin
            // Ready or timeout both release the pipe in the same cycle.
            if (bus.mem_ready_i) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else if (wait_q == WT_W'(MEM_TIMEOUT)) begin
               state_d = ST_RUN;
               wait_d  = '0;
               err_d   = 1'b1;
            end else begin
               freeze      = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               wait_d      = wait_q + WT_W'(1);
            end
         end
         default: begin
            if (bus.mem_req_i && !bus.mem_ready_i) begin
               freeze      = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               state_d     = ST_MEM_WAIT;
               wait_d      = WT_W'(1);
            end else if (bus.br_taken_i && (state_q != ST_BR_FLUSH)) begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               ex_m_flush  = 1'b1;
               flush_inc   = 1'b1;
               state_d     = ST_BR_FLUSH;
            end else if (load_use && (state_q == ST_RUN)) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               state_d     = ST_LU_STALL;
            end else begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .clear_i (1'b0),
      .inc_i   (!pc_write),
      .value_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .clear_i (1'b0),
      .inc_i   (flush_inc),
      .value_o (flush_cnt)
   );

   assign bus.pc_write_o    = pc_write;
   assign bus.if_id_write_o = if_id_write;
   assign bus.if_id_flush_o = if_id_flush;
   assign bus.id_ex_flush_o = id_ex_flush;
   assign bus.ex_m_flush_o  = ex_m_flush;
   assign bus.freeze_o      = freeze;
   assign bus.state_o       = state_q;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.flush_cnt_o   = flush_cnt;
   assign bus.err_o         = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench: main instance (MEM_TIMEOUT=64) plus a
// timeout/saturation instance (MEM_TIMEOUT=4, 2-bit counters).
module tb_pipe_hazard_ctrl;

   logic clk_i = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk_i = ~clk_i;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
   pipe_hazard_ctrl_if #(.CNT_W(2))  bus_to ();

   pipe_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(64)) dut (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut_to (
      .clk_i (clk_i),
      .rst_n (rst_n),
      .bus   (bus_to.slave)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge, then settle before checks.
   task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] exrt,
                                input logic memread, input logic br, input logic req, input logic rdy);
      bus.if_id_rs_i      = rs;
      bus.if_id_rt_i      = rt;
      bus.id_ex_rt_i      = exrt;
      bus.id_ex_memread_i = memread;
      bus.br_taken_i      = br;
      bus.mem_req_i       = req;
      bus.mem_ready_i     = rdy;
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [3:0] flushVec();
      return {bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_m_flush_o, bus.freeze_o};
   endfunction

   initial begin
      bus_to.if_id_rs_i      = 5'd0;
      bus_to.if_id_rt_i      = 5'd0;
      bus_to.id_ex_rt_i      = 5'd0;
      bus_to.id_ex_memread_i = 1'b0;
      bus_to.br_taken_i      = 1'b0;
      bus_to.mem_req_i       = 1'b0;
      bus_to.mem_ready_i     = 1'b0;
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_n = 1'b1;
      #1;

      // Reset state
      checkOutput("rst_state", bus.state_o, 0);
      checkOutput("rst_pc_write", bus.pc_write_o, 1);
      checkOutput("rst_if_id_write", bus.if_id_write_o, 1);
      checkOutput("rst_flush_freeze", flushVec(), 4'b0000);
      checkOutput("rst_stall_cnt", bus.stall_cnt_o, 0);
      checkOutput("rst_flush_cnt", bus.flush_cnt_o, 0);
      checkOutput("rst_err", bus.err_o, 0);
      nextCycle();

      // Load-use via rs
      applyStimulus(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_pc_write", bus.pc_write_o, 0);
      checkOutput("lu_if_id_write", bus.if_id_write_o, 0);
      checkOutput("lu_flush_freeze", flushVec(), 4'b0100);
      nextCycle();
      checkOutput("lu_state", bus.state_o, 1);
      checkOutput("lu_stall_cnt", bus.stall_cnt_o, 1);
      checkOutput("lu_no_restall_pc", bus.pc_write_o, 1);
      checkOutput("lu_no_restall_flush", flushVec(), 4'b0000);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkOutput("lu_back_run", bus.state_o, 0);

      // Zero-register guard, then load-use via rt
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("guard_pc_write", bus.pc_write_o, 1);
      checkOutput("guard_flush", flushVec(), 4'b0000);
      nextCycle();
      checkOutput("guard_state", bus.state_o, 0);
      applyStimulus(5'd4, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_rt_pc_write", bus.pc_write_o, 0);
      nextCycle();
      checkOutput("lu_rt_stall_cnt", bus.stall_cnt_o, 2);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      // Taken branch
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("br_flushes", flushVec(), 4'b1110);
      checkOutput("br_pc_write", bus.pc_write_o, 1);
      nextCycle();
      checkOutput("br_state", bus.state_o, 2);
      checkOutput("br_flush_cnt", bus.flush_cnt_o, 1);
      applyStimulus(5'd8, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("brf_lu_suppressed", bus.pc_write_o, 1);
      checkOutput("brf_no_flush", flushVec(), 4'b0000);
      nextCycle();
      checkOutput("brf_back_run", bus.state_o, 0);
      checkOutput("brf_flush_cnt_hold", bus.flush_cnt_o, 1);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();

      // Memory wait: 5 not-ready cycles (first also asserts branch; mem wins)
      for (int i = 0; i < 5; i++) begin
         applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, (i == 0), 1'b1, 1'b0);
         checkOutput($sformatf("mw_freeze_%0d", i), flushVec(), 4'b0001);
         checkOutput($sformatf("mw_pc_write_%0d", i), bus.pc_write_o, 0);
         nextCycle();
      end
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("mw_ready_state", bus.state_o, 3);
      checkOutput("mw_ready_freeze", bus.freeze_o, 0);
      checkOutput("mw_ready_pc_write", bus.pc_write_o, 1);
      nextCycle();
      checkOutput("mw_done_state", bus.state_o, 0);
      checkOutput("mw_stall_cnt", bus.stall_cnt_o, 7);
      checkOutput("mw_flush_cnt", bus.flush_cnt_o, 1);
      checkOutput("mw_err", bus.err_o, 0);
      applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Timeout instance: 4 frozen cycles, release on the 5th, err sticky
      bus_to.mem_req_i = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("to_freeze_%0d", i), bus_to.freeze_o, 1);
         nextCycle();
      end
      checkOutput("to_release_freeze", bus_to.freeze_o, 0);
      checkOutput("to_release_pc_write", bus_to.pc_write_o, 1);
      checkOutput("to_err_before", bus_to.err_o, 0);
      bus_to.mem_req_i = 1'b0;
      nextCycle();
      checkOutput("to_err_set", bus_to.err_o, 1);
      checkOutput("to_state_run", bus_to.state_o, 0);
      checkOutput("to_stall_sat", bus_to.stall_cnt_o, 3);
      repeat (3) nextCycle();
      checkOutput("to_err_sticky", bus_to.err_o, 1);

      // Reset in the middle of a new wait
      bus_to.mem_req_i = 1'b1;
      nextCycle();
      checkOutput("to_rewait_state", bus_to.state_o, 3);
      bus_to.mem_req_i = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("to_rst_state", bus_to.state_o, 0);
      checkOutput("to_rst_err", bus_to.err_o, 0);
      checkOutput("to_rst_freeze", bus_to.freeze_o, 0);
      checkOutput("to_rst_stall_cnt", bus_to.stall_cnt_o, 0);
      checkOutput("rst_main_flush_cnt", bus.flush_cnt_o, 0);
      checkOutput("rst_main_stall_cnt", bus.stall_cnt_o, 0);
      nextCycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
